regfile_commit_module: RTL and testbench

Architectural register file and rename-tag table. It is the consuming end of the ROB commit interface: it writes retired GPR values and NZCV flags in program order. It also tags each destination register with the producing ROB index at dispatch. Two source-operand read ports give dispatch either a committed value or the ROB index to wait on.

---
 rtl/regfile_commit_module.sv | 158 +++++++++++++++
 tb/tb_regfile_commit_module.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_commit_module.sv
// Architectural GPR file plus rename-tag table: retires ROB commits in order,
// tags destinations at dispatch and serves two source ports plus NZCV with commit bypass.
module regfile_commit_module #(
  parameter int GPR_COUNT = 32,
  parameter int GPR_WIDTH = 64,
  parameter int GPR_IDX_W = 5,
  parameter int ROB_IDX_W = 4,
  parameter int NZCV_W    = 4
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic                 in_commit_valid,
  input  logic [ROB_IDX_W-1:0] in_commit_rob_idx,
  input  logic                 in_commit_writes_gpr,
  input  logic [GPR_IDX_W-1:0] in_commit_gpr_idx,
  input  logic [GPR_WIDTH-1:0] in_commit_value,
  input  logic                 in_commit_set_nzcv,
  input  logic [NZCV_W-1:0]    in_commit_nzcv,
  input  logic                 in_disp_valid,
  input  logic [ROB_IDX_W-1:0] in_disp_rob_idx,
  input  logic                 in_disp_writes_gpr,
  input  logic [GPR_IDX_W-1:0] in_disp_dst_idx,
  input  logic                 in_disp_set_nzcv,
  input  logic                 in_flush,
  input  logic [GPR_IDX_W-1:0] in_src1_idx,
  input  logic [GPR_IDX_W-1:0] in_src2_idx,
  output logic [GPR_WIDTH-1:0] out_src1_value,
  output logic [GPR_WIDTH-1:0] out_src2_value,
  output logic                 out_src1_ready,
  output logic                 out_src2_ready,
  output logic [ROB_IDX_W-1:0] out_src1_rob_idx,
  output logic [ROB_IDX_W-1:0] out_src2_rob_idx,
  output logic [NZCV_W-1:0]    out_nzcv,
  output logic                 out_nzcv_ready,
  output logic [ROB_IDX_W-1:0] out_nzcv_rob_idx
);

  localparam logic [GPR_IDX_W-1:0] XZR_IDX = GPR_IDX_W'(GPR_COUNT - 1);

  logic [GPR_WIDTH-1:0] gpr_q     [GPR_COUNT];
  logic [GPR_WIDTH-1:0] gpr_d     [GPR_COUNT];
  logic [ROB_IDX_W-1:0] tag_idx_q [GPR_COUNT];
  logic [ROB_IDX_W-1:0] tag_idx_d [GPR_COUNT];
  logic [GPR_COUNT-1:0] tag_valid_q, tag_valid_d;
  logic [NZCV_W-1:0]    nzcv_q, nzcv_d;
  logic                 nzcv_tag_valid_q, nzcv_tag_valid_d;
  logic [ROB_IDX_W-1:0] nzcv_tag_idx_q, nzcv_tag_idx_d;

  logic commit_gpr, commit_nzcv, disp_gpr, disp_nzcv;

  assign commit_gpr  = in_commit_valid && in_commit_writes_gpr && (in_commit_gpr_idx != XZR_IDX);
  assign commit_nzcv = in_commit_valid && in_commit_set_nzcv;
  assign disp_gpr    = in_disp_valid && in_disp_writes_gpr && (in_disp_dst_idx != XZR_IDX) && !in_flush;
  assign disp_nzcv   = in_disp_valid && in_disp_set_nzcv && !in_flush;

  // NOTE: every *_d starts as a copy of its *_q so no path leaves a signal unassigned (no latch).
  always_comb begin
    gpr_d            = gpr_q;
    tag_idx_d        = tag_idx_q;
    tag_valid_d      = tag_valid_q;
    nzcv_d           = nzcv_q;
    nzcv_tag_valid_d = nzcv_tag_valid_q;
    nzcv_tag_idx_d   = nzcv_tag_idx_q;

    // A commit only retires the tag if it is still the newest producer.
    if (commit_gpr) begin
      gpr_d[in_commit_gpr_idx] = in_commit_value;
      if (tag_valid_q[in_commit_gpr_idx] && tag_idx_q[in_commit_gpr_idx] == in_commit_rob_idx)
        tag_valid_d[in_commit_gpr_idx] = 1'b0;
    end
    if (commit_nzcv) begin
      nzcv_d = in_commit_nzcv;
      if (nzcv_tag_valid_q && nzcv_tag_idx_q == in_commit_rob_idx)
        nzcv_tag_valid_d = 1'b0;
    end

    if (in_flush) begin
      tag_valid_d      = '0;
      nzcv_tag_valid_d = 1'b0;
    end

    // Dispatch is applied last so a same-cycle retag overrides the commit clear.
    if (disp_gpr) begin
      tag_valid_d[in_disp_dst_idx] = 1'b1;
      tag_idx_d[in_disp_dst_idx]   = in_disp_rob_idx;
    end
    if (disp_nzcv) begin
      nzcv_tag_valid_d = 1'b1;
      nzcv_tag_idx_d   = in_disp_rob_idx;
    end
  end

  // NOTE: state uses non-blocking assignments only; the GPR array is reset because reads must return 0 after reset.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      for (int i = 0; i < GPR_COUNT; i++) begin
        gpr_q[i]     <= '0;
        tag_idx_q[i] <= '0;
      end
      tag_valid_q      <= '0;
      nzcv_q           <= '0;
      nzcv_tag_valid_q <= 1'b0;
      nzcv_tag_idx_q   <= '0;
    end else begin
      gpr_q            <= gpr_d;
      tag_idx_q        <= tag_idx_d;
      tag_valid_q      <= tag_valid_d;
      nzcv_q           <= nzcv_d;
      nzcv_tag_valid_q <= nzcv_tag_valid_d;
      nzcv_tag_idx_q   <= nzcv_tag_idx_d;
    end
  end

  logic [GPR_IDX_W-1:0] src_idx  [2];
  logic [GPR_WIDTH-1:0] rd_value [2];
  logic                 rd_ready [2];
  logic [ROB_IDX_W-1:0] rd_rob   [2];

  assign src_idx[0] = in_src1_idx;
  assign src_idx[1] = in_src2_idx;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_value[p] = gpr_q[src_idx[p]];
      rd_ready[p] = 1'b1;
      rd_rob[p]   = tag_idx_q[src_idx[p]];
      if (src_idx[p] == XZR_IDX) begin
        rd_value[p] = '0;
      end else if (tag_valid_q[src_idx[p]]) begin
        if (in_commit_valid && in_commit_writes_gpr && in_commit_gpr_idx == src_idx[p] &&
            in_commit_rob_idx == tag_idx_q[src_idx[p]])
          rd_value[p] = in_commit_value;
        else
          rd_ready[p] = 1'b0;
      end
    end
  end

  assign out_src1_value   = rd_value[0];
  assign out_src1_ready   = rd_ready[0];
  assign out_src1_rob_idx = rd_rob[0];
  assign out_src2_value   = rd_value[1];
  assign out_src2_ready   = rd_ready[1];
  assign out_src2_rob_idx = rd_rob[1];

  always_comb begin
    out_nzcv         = nzcv_q;
    out_nzcv_ready   = 1'b1;
    out_nzcv_rob_idx = nzcv_tag_idx_q;
    if (nzcv_tag_valid_q) begin
      if (commit_nzcv && in_commit_rob_idx == nzcv_tag_idx_q)
        out_nzcv = in_commit_nzcv;
      else
        out_nzcv_ready = 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_commit_module.sv
// Scoreboard bench for regfile_commit_module: expected port reads are queued as
// stimulus is driven and compared against the combinational outputs mid-cycle.
module tb_regfile_commit_module;

  logic        in_clk = 1'b0;
  logic        in_rst;
  logic        in_commit_valid;
  logic [3:0]  in_commit_rob_idx;
  logic        in_commit_writes_gpr;
  logic [4:0]  in_commit_gpr_idx;
  logic [63:0] in_commit_value;
  logic        in_commit_set_nzcv;
  logic [3:0]  in_commit_nzcv;
  logic        in_disp_valid;
  logic [3:0]  in_disp_rob_idx;
  logic        in_disp_writes_gpr;
  logic [4:0]  in_disp_dst_idx;
  logic        in_disp_set_nzcv;
  logic        in_flush;
  logic [4:0]  in_src1_idx, in_src2_idx;
  logic [63:0] out_src1_value, out_src2_value;
  logic        out_src1_ready, out_src2_ready;
  logic [3:0]  out_src1_rob_idx, out_src2_rob_idx;
  logic [3:0]  out_nzcv;
  logic        out_nzcv_ready;
  logic [3:0]  out_nzcv_rob_idx;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    int          port;     // 0 = src1, 1 = src2, 2 = nzcv
    logic        ready;
    logic [63:0] value;
    logic [3:0]  rob;
    bit          chk_rob;
  } exp_t;

  exp_t sb[$];

  regfile_commit_module dut (
    .in_clk(in_clk), .in_rst(in_rst),
    .in_commit_valid(in_commit_valid), .in_commit_rob_idx(in_commit_rob_idx),
    .in_commit_writes_gpr(in_commit_writes_gpr), .in_commit_gpr_idx(in_commit_gpr_idx),
    .in_commit_value(in_commit_value), .in_commit_set_nzcv(in_commit_set_nzcv),
    .in_commit_nzcv(in_commit_nzcv),
    .in_disp_valid(in_disp_valid), .in_disp_rob_idx(in_disp_rob_idx),
    .in_disp_writes_gpr(in_disp_writes_gpr), .in_disp_dst_idx(in_disp_dst_idx),
    .in_disp_set_nzcv(in_disp_set_nzcv), .in_flush(in_flush),
    .in_src1_idx(in_src1_idx), .in_src2_idx(in_src2_idx),
    .out_src1_value(out_src1_value), .out_src2_value(out_src2_value),
    .out_src1_ready(out_src1_ready), .out_src2_ready(out_src2_ready),
    .out_src1_rob_idx(out_src1_rob_idx), .out_src2_rob_idx(out_src2_rob_idx),
    .out_nzcv(out_nzcv), .out_nzcv_ready(out_nzcv_ready), .out_nzcv_rob_idx(out_nzcv_rob_idx)
  );

  always #5 in_clk = ~in_clk;

  task automatic idle_inputs();
    in_rst = 1'b0;
    in_commit_valid = 1'b0; in_commit_rob_idx = '0; in_commit_writes_gpr = 1'b0;
    in_commit_gpr_idx = '0; in_commit_value = '0; in_commit_set_nzcv = 1'b0; in_commit_nzcv = '0;
    in_disp_valid = 1'b0; in_disp_rob_idx = '0; in_disp_writes_gpr = 1'b0;
    in_disp_dst_idx = '0; in_disp_set_nzcv = 1'b0; in_flush = 1'b0;
    in_src1_idx = '0; in_src2_idx = '0;
  endtask

  // Start a new cycle: inputs change just after the falling edge.
  task automatic next_cycle();
    @(negedge in_clk);
    idle_inputs();
  endtask

  task automatic commit(input logic [3:0] rob, input logic [4:0] idx, input logic [63:0] val);
    in_commit_valid = 1'b1; in_commit_rob_idx = rob;
    in_commit_writes_gpr = 1'b1; in_commit_gpr_idx = idx; in_commit_value = val;
  endtask

  task automatic dispatch(input logic [3:0] rob, input logic [4:0] dst, input logic nz);
    in_disp_valid = 1'b1; in_disp_rob_idx = rob;
    in_disp_writes_gpr = 1'b1; in_disp_dst_idx = dst; in_disp_set_nzcv = nz;
  endtask

  task automatic expect_rd(input string name, input int port, input logic rdy,
                           input logic [63:0] val, input logic [3:0] rob, input bit chk_rob);
    exp_t e;
    e.name = name; e.port = port; e.ready = rdy; e.value = val; e.rob = rob; e.chk_rob = chk_rob;
    sb.push_back(e);
  endtask

  // Scoreboard consumer: let the combinational outputs settle, then retire every queued expectation.
  task automatic score_cycle();
    exp_t        e;
    logic        a_rdy;
    logic [63:0] a_val;
    logic [3:0]  a_rob;
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.port)
        0:       begin a_rdy = out_src1_ready; a_val = out_src1_value; a_rob = out_src1_rob_idx; end
        1:       begin a_rdy = out_src2_ready; a_val = out_src2_value; a_rob = out_src2_rob_idx; end
        default: begin a_rdy = out_nzcv_ready; a_val = {60'd0, out_nzcv}; a_rob = out_nzcv_rob_idx; end
      endcase
      checks++;
      if (a_rdy !== e.ready || (e.ready && a_val !== e.value) || (e.chk_rob && a_rob !== e.rob)) begin
        failures++;
        $display("FAIL %s: got ready=%0b value=%h rob=%0d, expected ready=%0b value=%h rob=%0d",
                 e.name, a_rdy, a_val, a_rob, e.ready, e.value, e.rob);
      end
    end
  endtask

  task automatic test_reset();
    next_cycle(); in_rst = 1'b1;
    next_cycle(); in_rst = 1'b1;
    next_cycle();
    in_src1_idx = 5'd3; in_src2_idx = 5'd31;
    expect_rd("reset_src1", 0, 1'b1, 64'd0, 4'd0, 1'b1);
    expect_rd("reset_src2_xzr", 1, 1'b1, 64'd0, 4'd0, 1'b1);
    expect_rd("reset_nzcv", 2, 1'b1, 64'd0, 4'd0, 1'b1);
    score_cycle();
  endtask

  task automatic test_bypass();
    next_cycle(); dispatch(4'd5, 5'd3, 1'b0); in_src1_idx = 5'd3;
    expect_rd("disp_same_cycle_pre_state", 0, 1'b1, 64'd0, 4'd0, 1'b0);
    score_cycle();
    next_cycle(); in_src1_idx = 5'd3;
    expect_rd("tagged_wait", 0, 1'b0, 64'd0, 4'd5, 1'b1);
    score_cycle();
    next_cycle(); commit(4'd5, 5'd3, 64'hDEAD); in_src1_idx = 5'd3; in_src2_idx = 5'd3;
    expect_rd("commit_bypass_src1", 0, 1'b1, 64'hDEAD, 4'd0, 1'b0);
    expect_rd("commit_bypass_src2", 1, 1'b1, 64'hDEAD, 4'd0, 1'b0);
    score_cycle();
    next_cycle(); in_src1_idx = 5'd3;
    expect_rd("after_commit_gpr", 0, 1'b1, 64'hDEAD, 4'd0, 1'b0);
    score_cycle();
  endtask

  task automatic test_nzcv();
    next_cycle(); in_disp_valid = 1'b1; in_disp_rob_idx = 4'd8; in_disp_set_nzcv = 1'b1;
    score_cycle();
    next_cycle();
    expect_rd("nzcv_wait", 2, 1'b0, 64'd0, 4'd8, 1'b1);
    score_cycle();
    next_cycle(); in_commit_valid = 1'b1; in_commit_rob_idx = 4'd8;
    in_commit_set_nzcv = 1'b1; in_commit_nzcv = 4'hA;
    expect_rd("nzcv_bypass", 2, 1'b1, 64'hA, 4'd0, 1'b0);
    score_cycle();
    next_cycle();
    expect_rd("nzcv_committed", 2, 1'b1, 64'hA, 4'd0, 1'b0);
    score_cycle();
  endtask

  task automatic test_younger_producer();
    next_cycle(); dispatch(4'd2, 5'd7, 1'b0); score_cycle();
    next_cycle(); dispatch(4'd3, 5'd7, 1'b0); score_cycle();
    next_cycle(); commit(4'd2, 5'd7, 64'h11); in_src1_idx = 5'd7;
    expect_rd("older_commit_no_bypass", 0, 1'b0, 64'd0, 4'd3, 1'b1);
    score_cycle();
    next_cycle(); in_src2_idx = 5'd7;
    expect_rd("older_commit_tag_kept", 1, 1'b0, 64'd0, 4'd3, 1'b1);
    score_cycle();
    next_cycle(); commit(4'd3, 5'd7, 64'h22); in_src2_idx = 5'd7;
    expect_rd("younger_commit_bypass", 1, 1'b1, 64'h22, 4'd0, 1'b0);
    score_cycle();
    next_cycle(); in_src1_idx = 5'd7;
    expect_rd("younger_commit_final", 0, 1'b1, 64'h22, 4'd0, 1'b0);
    score_cycle();
  endtask

  task automatic test_back_to_back();
    next_cycle(); commit(4'd4, 5'd1, 64'h55); dispatch(4'd9, 5'd1, 1'b0); score_cycle();
    next_cycle(); in_src1_idx = 5'd1;
    expect_rd("commit_disp_same_reg_tag", 0, 1'b0, 64'd0, 4'd9, 1'b1);
    score_cycle();
    // Flushing exposes the value the commit wrote underneath the new tag.
    next_cycle(); in_flush = 1'b1; score_cycle();
    next_cycle(); in_src1_idx = 5'd1;
    expect_rd("commit_disp_same_reg_value", 0, 1'b1, 64'h55, 4'd0, 1'b0);
    score_cycle();
  endtask

  task automatic test_flush();
    next_cycle(); commit(4'd12, 5'd2, 64'h2222); in_commit_set_nzcv = 1'b1; in_commit_nzcv = 4'h5;
    score_cycle();
    next_cycle(); commit(4'd13, 5'd4, 64'h4444); score_cycle();
    next_cycle(); dispatch(4'd6, 5'd2, 1'b1); score_cycle();
    next_cycle(); dispatch(4'd10, 5'd4, 1'b0); score_cycle();
    next_cycle(); in_src1_idx = 5'd2; in_src2_idx = 5'd4;
    expect_rd("pre_flush_x2", 0, 1'b0, 64'd0, 4'd6, 1'b1);
    expect_rd("pre_flush_x4", 1, 1'b0, 64'd0, 4'd10, 1'b1);
    expect_rd("pre_flush_nzcv", 2, 1'b0, 64'd0, 4'd6, 1'b1);
    score_cycle();
    next_cycle(); in_flush = 1'b1; commit(4'd1, 5'd5, 64'h77); dispatch(4'd11, 5'd6, 1'b1);
    score_cycle();
    next_cycle(); in_src1_idx = 5'd2; in_src2_idx = 5'd4;
    expect_rd("flush_x2", 0, 1'b1, 64'h2222, 4'd0, 1'b0);
    expect_rd("flush_x4", 1, 1'b1, 64'h4444, 4'd0, 1'b0);
    expect_rd("flush_nzcv", 2, 1'b1, 64'h5, 4'd0, 1'b0);
    score_cycle();
    next_cycle(); in_src1_idx = 5'd5; in_src2_idx = 5'd6;
    expect_rd("flush_commit_written", 0, 1'b1, 64'h77, 4'd0, 1'b0);
    expect_rd("flush_disp_ignored", 1, 1'b1, 64'd0, 4'd0, 1'b0);
    score_cycle();
  endtask

  task automatic test_xzr();
    next_cycle(); commit(4'd7, 5'd31, 64'hFF); dispatch(4'd7, 5'd31, 1'b0); in_src1_idx = 5'd31;
    expect_rd("xzr_during_write", 0, 1'b1, 64'd0, 4'd0, 1'b0);
    score_cycle();
    next_cycle(); in_src1_idx = 5'd31; in_src2_idx = 5'd31;
    expect_rd("xzr_after_write_src1", 0, 1'b1, 64'd0, 4'd0, 1'b0);
    expect_rd("xzr_after_write_src2", 1, 1'b1, 64'd0, 4'd0, 1'b0);
    score_cycle();
  endtask

  task automatic test_reset_mid();
    next_cycle(); dispatch(4'd2, 5'd3, 1'b1); score_cycle();
    next_cycle(); in_rst = 1'b1; commit(4'd14, 5'd8, 64'h99); dispatch(4'd15, 5'd9, 1'b1);
    score_cycle();
    next_cycle(); in_src1_idx = 5'd3; in_src2_idx = 5'd7;
    expect_rd("midreset_x3", 0, 1'b1, 64'd0, 4'd0, 1'b1);
    expect_rd("midreset_x7", 1, 1'b1, 64'd0, 4'd0, 1'b1);
    expect_rd("midreset_nzcv", 2, 1'b1, 64'd0, 4'd0, 1'b1);
    score_cycle();
    next_cycle(); in_src1_idx = 5'd8; in_src2_idx = 5'd9;
    expect_rd("midreset_commit_dropped", 0, 1'b1, 64'd0, 4'd0, 1'b1);
    expect_rd("midreset_disp_dropped", 1, 1'b1, 64'd0, 4'd0, 1'b1);
    score_cycle();
  endtask

  initial begin
    idle_inputs();
    in_rst = 1'b1;
    test_reset();
    test_bypass();
    test_nzcv();
    test_younger_producer();
    test_back_to_back();
    test_flush();
    test_xzr();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
